// File: rtl/tile_ram_arbiter.sv
// Arbitrates one read port and one write port of a single-port-per-direction tile RAM
// between the video fetcher, the game logic, and a block-fill engine.
module tile_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_ren,
  input  logic [ADDR_W-1:0] vid_raddr,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_rreq,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic              cpu_rgnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cpu_wreq,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_wgnt,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;
  localparam logic [ADDR_W:0]   LEN_ZERO = '0;

  fill_state_t       r_state;
  logic [ADDR_W-1:0] r_fillAddr;
  logic [ADDR_W:0]   r_fillRemain;
  logic [DATA_W-1:0] r_fillData;
  logic              r_fillBusy;
  logic              r_fillDone;
  logic              r_vidTag;
  logic              r_cpuTag;
  logic [DATA_W-1:0] r_cpuHold;
  logic              w_fillWrite;

  assign ram_ren   = vid_ren | cpu_rreq;
  assign ram_raddr = vid_ren ? vid_raddr : cpu_raddr;
  assign cpu_rgnt  = cpu_rreq & ~vid_ren;

  // The tags remember who owned last cycle's read so the RAM's 1-cycle data goes to the right requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vidTag  <= 1'b0;
      r_cpuTag  <= 1'b0;
      r_cpuHold <= '0;
    end else begin
      r_vidTag <= vid_ren;
      r_cpuTag <= cpu_rgnt;
      if (r_cpuTag) begin
        r_cpuHold <= ram_rdata;
      end
    end
  end

  assign vid_rvalid = r_vidTag;
  assign vid_rdata  = ram_rdata;
  assign cpu_rvalid = r_cpuTag;
  assign cpu_rdata  = r_cpuTag ? ram_rdata : r_cpuHold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_fillAddr   <= '0;
      r_fillRemain <= '0;
      r_fillData   <= '0;
      r_fillBusy   <= 1'b0;
      r_fillDone   <= 1'b0;
    end else begin
      r_fillDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (fill_start) begin
            r_fillAddr   <= fill_base;
            r_fillRemain <= fill_len;
            r_fillData   <= fill_data;
            r_fillBusy   <= 1'b1;
            if (fill_len == LEN_ZERO) begin
              r_state    <= DONE;
              r_fillDone <= 1'b1;
            end else begin
              r_state <= FILL;
            end
          end
        end
        FILL: begin
          r_fillAddr   <= r_fillAddr + ADDR_ONE;
          r_fillRemain <= r_fillRemain - LEN_ONE;
          if (r_fillRemain == LEN_ONE) begin
            r_state    <= DONE;
            r_fillDone <= 1'b1;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_fillBusy <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_fillBusy <= 1'b0;
        end
      endcase
    end
  end

  // The fill engine owns the write port while filling; reset blocks any cpu write from reaching the RAM.
  assign w_fillWrite = (r_state == FILL);
  assign cpu_wgnt    = cpu_wreq & ~w_fillWrite & ~rst;
  assign ram_wen     = w_fillWrite | cpu_wgnt;
  assign ram_waddr   = w_fillWrite ? r_fillAddr : cpu_waddr;
  assign ram_wdata   = w_fillWrite ? r_fillData : cpu_wdata;
  assign fill_busy   = r_fillBusy;
  assign fill_done   = r_fillDone;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Randomized and directed bench for tile_ram_arbiter; a read-first RAM sits behind the DUT
// and a cycle-indexed reference model predicts every port.
module tb_tile_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          vid_ren, cpu_rreq, cpu_wreq, fill_start;
  logic [AW-1:0] vid_raddr, cpu_raddr, cpu_waddr, fill_base;
  logic [AW:0]   fill_len;
  logic [DW-1:0] cpu_wdata, fill_data;
  logic          vid_rvalid, cpu_rgnt, cpu_rvalid, cpu_wgnt, fill_busy, fill_done;
  logic [DW-1:0] vid_rdata, cpu_rdata;
  logic          ram_ren, ram_wen;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [DW-1:0] ram_rdata, ram_wdata;

  tile_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .vid_ren(vid_ren), .vid_raddr(vid_raddr), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .cpu_rreq(cpu_rreq), .cpu_raddr(cpu_raddr), .cpu_rgnt(cpu_rgnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cpu_wreq(cpu_wreq), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_wgnt(cpu_wgnt),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_data(fill_data),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
  );

  always #5 clk = ~clk;

  // Read-first RAM attached to the DUT's RAM ports.
  logic [DW-1:0] ramMem [4096];
  logic [DW-1:0] ramQ;
  logic          ramInit;
  int            patSeed;

  function automatic logic [DW-1:0] initPattern(input int a, input int seed);
    return DW'((a * 977 + seed) ^ (a >> 3));
  endfunction

  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < 4096; i++) ramMem[i] <= initPattern(i, patSeed);
    end else begin
      if (ram_ren) ramQ <= ramMem[ram_raddr];
      if (ram_wen) ramMem[ram_waddr] <= ram_wdata;
    end
  end
  assign ram_rdata = ramQ;

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state: a fill accepted at cycle s writes cycles s+1..s+len and is done at s+len+1.
  logic [DW-1:0] refMem [4096];
  int            cyc = 0;
  int            startCycle, doneCycle, fLen, fBase;
  logic [DW-1:0] fData;
  logic          expVidValid, expCpuValid;
  logic [DW-1:0] expVidData, expCpuData;
  int            writeCount;

  task automatic modelReset();
    startCycle  = -100;
    doneCycle   = -100;
    fLen        = 0;
    fBase       = 0;
    fData       = '0;
    expVidValid = 1'b0;
    expCpuValid = 1'b0;
    expVidData  = '0;
    expCpuData  = '0;
  endtask

  task automatic applyStimulus(
    input logic vr, input logic [AW-1:0] va,
    input logic cr, input logic [AW-1:0] ca,
    input logic cw, input logic [AW-1:0] cwa, input logic [DW-1:0] cwd,
    input logic fs, input logic [AW-1:0] fb, input logic [AW:0] fl, input logic [DW-1:0] fd);
    logic          busyExp, fillWr, wgntExp, rgntExp;
    logic [AW-1:0] fAddr;
    busyExp = (cyc > startCycle) && (cyc <= doneCycle);
    checkOutput("fill_busy", fill_busy, busyExp);
    checkOutput("fill_done", fill_done, cyc == doneCycle);
    checkOutput("vid_rvalid", vid_rvalid, expVidValid);
    if (expVidValid) checkOutput("vid_rdata", vid_rdata, expVidData);
    checkOutput("cpu_rvalid", cpu_rvalid, expCpuValid);
    checkOutput("cpu_rdata", cpu_rdata, expCpuData);

    vid_ren = vr; vid_raddr = va; cpu_rreq = cr; cpu_raddr = ca;
    cpu_wreq = cw; cpu_waddr = cwa; cpu_wdata = cwd;
    fill_start = fs; fill_base = fb; fill_len = fl; fill_data = fd;
    #1;
    fillWr  = (cyc > startCycle) && (cyc <= startCycle + fLen);
    fAddr   = AW'((fBase + (cyc - startCycle - 1)) % 4096);
    wgntExp = cw && !fillWr;
    rgntExp = cr && !vr;
    checkOutput("ram_ren", ram_ren, vr || cr);
    if (vr || cr) checkOutput("ram_raddr", ram_raddr, vr ? va : ca);
    checkOutput("cpu_rgnt", cpu_rgnt, rgntExp);
    checkOutput("cpu_wgnt", cpu_wgnt, wgntExp);
    checkOutput("ram_wen", ram_wen, fillWr || wgntExp);
    if (fillWr) begin
      checkOutput("fill_waddr", ram_waddr, fAddr);
      checkOutput("fill_wdata", ram_wdata, fData);
    end else if (wgntExp) begin
      checkOutput("cpu_waddr", ram_waddr, cwa);
      checkOutput("cpu_wdata", ram_wdata, cwd);
    end
    if (ram_wen === 1'b1) writeCount++;

    expVidValid = vr;
    if (vr) expVidData = refMem[va];
    expCpuValid = rgntExp;
    if (rgntExp) expCpuData = refMem[ca];
    if (fillWr) refMem[fAddr] = fData;
    else if (wgntExp) refMem[cwa] = cwd;
    if (fs && !busyExp) begin
      startCycle = cyc;
      fLen       = int'(fl);
      fBase      = int'(fb);
      fData      = fd;
      doneCycle  = cyc + fLen + 1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    vid_ren = 1'b1; vid_raddr = 12'h055; cpu_rreq = 1'b0; cpu_raddr = '0;
    cpu_wreq = 1'b1; cpu_waddr = 12'h077; cpu_wdata = 12'h123;
    fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_data = '0;
    #1;
    checkOutput("rst_ram_ren", ram_ren, 1);
    checkOutput("rst_ram_raddr", ram_raddr, 12'h055);
    checkOutput("rst_ram_wen", ram_wen, 0);
    checkOutput("rst_fill_busy", fill_busy, 0);
    checkOutput("rst_fill_done", fill_done, 0);
    checkOutput("rst_vid_rvalid", vid_rvalid, 0);
    checkOutput("rst_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 0);
    @(posedge clk); #1;
    checkOutput("rst_hold_vid_rvalid", vid_rvalid, 0);
    checkOutput("rst_hold_ram_wen", ram_wen, 0);
    vid_ren = 1'b0; cpu_wreq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc += 2;
    modelReset();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int writesBefore;
    logic vr, cr, cw, fs;
    logic [AW-1:0] fb;
    rst = 1'b1; ramInit = 1'b1; writeCount = 0;
    vid_ren = 0; vid_raddr = 0; cpu_rreq = 0; cpu_raddr = 0; cpu_wreq = 0; cpu_waddr = 0; cpu_wdata = 0;
    fill_start = 0; fill_base = 0; fill_len = 0; fill_data = 0;
    patSeed = int'($urandom_range(0, 4095));
    for (int i = 0; i < 4096; i++) refMem[i] = initPattern(i, patSeed);
    modelReset();
    @(posedge clk); #1;
    ramInit = 1'b0;
    applyReset();

    $display("[TB] video/cpu read contention");
    applyStimulus(1, 12'h010, 1, 12'h020, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 12'h020, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(2);

    $display("[TB] cpu read with video idle, then back-to-back video reads");
    applyStimulus(0, 0, 1, 12'h123, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(2);
    for (int i = 0; i < 4; i++) applyStimulus(1, AW'(12'h200 + i), 1, 12'h300, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 12'h300, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(2);

    $display("[TB] wrapping fill with an ignored restart");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'hFFE, 13'd4, 12'hABC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h400, 13'd2, 12'h111);
    idleCycles(4);
    applyStimulus(0, 0, 1, 12'hFFF, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 12'h001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(1);

    $display("[TB] cpu write held through a 3-word fill");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 12'h050, 12'h5A5, i == 0, 12'h040, 13'd3, 12'h321);
    idleCycles(1);

    $display("[TB] zero-length fill and reset mid-fill");
    writesBefore = writeCount;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h600, 13'd0, 12'hFFF);
    idleCycles(2);
    checkOutput("len0_no_writes", writeCount - writesBefore, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12'h700, 13'd8, 12'h0F0);
    idleCycles(2);
    applyReset();
    writesBefore = writeCount;
    idleCycles(12);
    checkOutput("abort_no_writes", writeCount - writesBefore, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      vr = ($urandom_range(0, 1) == 1);
      cr = ($urandom_range(0, 1) == 1);
      cw = ($urandom_range(0, 2) == 0);
      fs = ($urandom_range(0, 19) == 0);
      fb = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(4080, 4095)) : AW'($urandom);
      applyStimulus(vr, AW'($urandom), cr, AW'($urandom), cw, AW'($urandom), DW'($urandom),
                    fs, fb, (AW+1)'($urandom_range(0, 12)), DW'($urandom));
    end
    idleCycles(16);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
